// File: rtl/mem_wb_reg_pkg.sv
// Shared processor constants: writeback source selects and load funct3 codes.
// Both the MEM/WB register and its load extension logic import this package.
package mem_wb_reg_pkg;

    typedef logic [1:0] result_src_t;
    typedef logic [2:0] funct3_t;

    // A select of 2'b11 behaves like RESULT_PC4 at the writeback mux.
    localparam result_src_t RESULT_ALU = 2'b00;
    localparam result_src_t RESULT_MEM = 2'b01;
    localparam result_src_t RESULT_PC4 = 2'b10;

    localparam funct3_t F3_LB  = 3'b000;
    localparam funct3_t F3_LH  = 3'b001;
    localparam funct3_t F3_LW  = 3'b010;
    localparam funct3_t F3_LBU = 3'b100;
    localparam funct3_t F3_LHU = 3'b101;

    localparam int unsigned RETIRE_CNT_W = 32;

endpackage

// File: rtl/mem_wb_reg_load_extend.sv
// Combinational load alignment: selects a byte/halfword from the raw aligned
// memory word by address offset and sign- or zero-extends it.
module load_extend
    import mem_wb_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_offset,
    input  logic [2:0]            i_funct3,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = i_rdata[7:0];
        case (i_offset)
            2'd0: byte_sel = i_rdata[7:0];
            2'd1: byte_sel = i_rdata[15:8];
            2'd2: byte_sel = i_rdata[23:16];
            2'd3: byte_sel = i_rdata[31:24];
            default: byte_sel = i_rdata[7:0];
        endcase
        // Halfword loads ignore offset bit 0.
        half_sel = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  o_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   o_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  o_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load extension at capture and a retired-
// instruction counter. Flush beats stall; synchronous reset beats both.
module mem_wb_reg
    import mem_wb_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [DATA_WIDTH-1:0] i_pc_plus4,
    input  logic [4:0]            i_rd_addr,
    input  logic                  i_reg_write,
    input  logic [1:0]            i_result_src,
    input  logic [2:0]            i_funct3,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic [DATA_WIDTH-1:0] o_pc_plus4,
    output logic [4:0]            o_rd_addr,
    output logic                  o_reg_write,
    output logic [1:0]            o_result_src,
    output logic [31:0]           o_retire_cnt
);

    logic                    valid_q,     valid_d;
    logic [DATA_WIDTH-1:0]   alu_q,       alu_d;
    logic [DATA_WIDTH-1:0]   load_q,      load_d;
    logic [DATA_WIDTH-1:0]   pc4_q,       pc4_d;
    logic [4:0]              rd_q,        rd_d;
    logic                    rw_q,        rw_d;
    result_src_t             rs_q,        rs_d;
    logic [RETIRE_CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    logic [DATA_WIDTH-1:0]   load_ext;
    logic                    retire;

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .i_rdata  (i_rdata),
        .i_offset (i_alu_result[1:0]),
        .i_funct3 (i_funct3),
        .o_data   (load_ext)
    );

    // The held instruction leaves WB when the stage advances or is flushed,
    // so a long stall still counts it exactly once.
    assign retire = valid_q && (!i_stall || i_flush);

    always_comb begin
        valid_d      = valid_q;
        alu_d        = alu_q;
        load_d       = load_q;
        pc4_d        = pc4_q;
        rd_d         = rd_q;
        rw_d         = rw_q;
        rs_d         = rs_q;
        retire_cnt_d = retire_cnt_q + {{(RETIRE_CNT_W-1){1'b0}}, retire};
        if (i_flush) begin
            valid_d = 1'b0;
            alu_d   = '0;
            load_d  = '0;
            pc4_d   = '0;
            rd_d    = '0;
            rw_d    = 1'b0;
            rs_d    = RESULT_ALU;
        end else if (!i_stall) begin
            valid_d = i_valid;
            alu_d   = i_alu_result;
            load_d  = load_ext;
            pc4_d   = i_pc_plus4;
            rd_d    = i_rd_addr;
            rw_d    = i_reg_write && i_valid && (i_rd_addr != 5'd0);
            rs_d    = i_result_src;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q      <= 1'b0;
            alu_q        <= '0;
            load_q       <= '0;
            pc4_q        <= '0;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            rs_q         <= RESULT_ALU;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_q        <= alu_d;
            load_q       <= load_d;
            pc4_q        <= pc4_d;
            rd_q         <= rd_d;
            rw_q         <= rw_d;
            rs_q         <= rs_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_alu_result = alu_q;
    assign o_load_data  = load_q;
    assign o_pc_plus4   = pc4_q;
    assign o_rd_addr    = rd_q;
    assign o_reg_write  = rw_q;
    assign o_result_src = rs_q;
    assign o_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_reg.sv
// Bench for mem_wb_reg: directed load/stall/flush/reset steps plus random
// traffic, each cycle compared against an arithmetic reference model.
module tb_mem_wb_reg;

    localparam int DW = 32;
    localparam int EW = 1 + DW * 3 + 5 + 1 + 2 + 32;

    logic          clk = 1'b0;
    logic          rst, stall, flush, valid, reg_write;
    logic [DW-1:0] alu, rdata, pc4;
    logic [4:0]    rd;
    logic [1:0]    rsrc;
    logic [2:0]    f3;

    logic          o_valid, o_reg_write;
    logic [DW-1:0] o_alu, o_load, o_pc4;
    logic [4:0]    o_rd;
    logic [1:0]    o_rsrc;
    logic [31:0]   o_cnt;

    // Reference model state (what WB should hold after each edge).
    logic          m_valid, m_rw;
    logic [DW-1:0] m_alu, m_load, m_pc4;
    logic [4:0]    m_rd;
    logic [1:0]    m_rsrc;
    logic [31:0]   m_cnt;

    logic [EW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_wb_reg #(.DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_alu_result(alu), .i_rdata(rdata),
        .i_pc_plus4(pc4), .i_rd_addr(rd), .i_reg_write(reg_write),
        .i_result_src(rsrc), .i_funct3(f3),
        .o_valid(o_valid), .o_alu_result(o_alu), .o_load_data(o_load),
        .o_pc_plus4(o_pc4), .o_rd_addr(o_rd), .o_reg_write(o_reg_write),
        .o_result_src(o_rsrc), .o_retire_cnt(o_cnt)
    );

    // Load value from the ISA rules, using shifts and magnitude tests.
    function automatic logic [31:0] ref_load(logic [31:0] w, logic [31:0] a, logic [2:0] fn);
        int unsigned b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (fn)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_valid = 0; m_rw = 0; m_alu = 0; m_load = 0; m_pc4 = 0;
            m_rd = 0; m_rsrc = 0; m_cnt = 0;
        end else begin
            if (m_valid && (!stall || flush)) m_cnt = m_cnt + 1;
            if (flush) begin
                m_valid = 0; m_rw = 0; m_alu = 0; m_load = 0; m_pc4 = 0;
                m_rd = 0; m_rsrc = 0;
            end else if (!stall) begin
                m_valid = valid;
                m_rw    = reg_write && valid && (rd != 0);
                m_alu   = alu;
                m_load  = ref_load(rdata, alu, f3);
                m_pc4   = pc4;
                m_rd    = rd;
                m_rsrc  = rsrc;
            end
        end
        exp_q.push_back({m_valid, m_alu, m_load, m_pc4, m_rd, m_rw, m_rsrc, m_cnt});
    endtask

    task automatic compare_outputs();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check("valid",      64'(o_valid),     64'(e[EW-1]));
        check("alu_result", 64'(o_alu),       64'(e[EW-2 -: DW]));
        check("load_data",  64'(o_load),      64'(e[EW-2-DW -: DW]));
        check("pc_plus4",   64'(o_pc4),       64'(e[EW-2-2*DW -: DW]));
        check("rd_addr",    64'(o_rd),        64'(e[39:35]));
        check("reg_write",  64'(o_reg_write), 64'(e[34]));
        check("result_src", 64'(o_rsrc),      64'(e[33:32]));
        check("retire_cnt", 64'(o_cnt),       64'(e[31:0]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic drive(logic v, logic [31:0] a, logic [31:0] d, logic [4:0] r,
                         logic w, logic [1:0] s, logic [2:0] fn);
        valid = v; alu = a; rdata = d; pc4 = $urandom; rd = r;
        reg_write = w; rsrc = s; f3 = fn;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        drive(1, 32'h1234_5678, 32'hDEAD_BEEF, 5'd7, 1, 2'b01, 3'd2);
        m_cnt = 0;
        tick();
        tick();
        rst = 0;

        // Sign/zero-extension directed cases.
        drive(1, 32'h0000_1003, 32'h80FF_7F01, 5'd3, 1, 2'b01, 3'b000);
        tick(); check("lb_const", 64'(o_load), 64'h0000_0000_FFFF_FF80);
        drive(1, 32'h0000_1003, 32'h80FF_7F01, 5'd3, 1, 2'b01, 3'b100);
        tick(); check("lbu_const", 64'(o_load), 64'h0000_0000_0000_0080);
        drive(1, 32'h0000_2002, 32'h8001_1234, 5'd4, 1, 2'b01, 3'b001);
        tick(); check("lh_const", 64'(o_load), 64'h0000_0000_FFFF_8001);
        drive(1, 32'h0000_2003, 32'h8001_1234, 5'd4, 1, 2'b01, 3'b010);
        tick(); check("lw_const", 64'(o_load), 64'h0000_0000_8001_1234);

        // Stall for three cycles, then release; then stall+flush gives a bubble.
        drive(1, 32'hA5A5_0000, 32'h0, 5'd5, 1, 2'b00, 3'b010);
        tick(); check("rd5_write", 64'(o_reg_write), 64'd1);
        drive(1, 32'h1111_1111, 32'h2222_2222, 5'd9, 1, 2'b10, 3'b000);
        stall = 1;
        repeat (3) begin
            tick(); check("stall_hold_rd", 64'(o_rd), 64'd5);
        end
        stall = 0;
        tick(); check("release_rd", 64'(o_rd), 64'd9);
        stall = 1; flush = 1;
        tick(); check("stall_flush_bubble", 64'(o_valid), 64'd0);
        stall = 0; flush = 0;

        // x0 write is suppressed but the instruction is still valid.
        drive(1, 32'h0, 32'h0, 5'd0, 1, 2'b00, 3'b010);
        tick();
        check("x0_rw", 64'(o_reg_write), 64'd0);
        check("x0_valid", 64'(o_valid), 64'd1);
        drive(1, 32'h0, 32'h0, 5'd1, 1, 2'b11, 3'b010);
        tick(); check("rsrc_11_stored", 64'(o_rsrc), 64'd3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0; stall = 0; flush = 0;

        // Counter wrap: preload the counter with a valid instruction in WB.
        drive(1, 32'h4, 32'h0, 5'd2, 1, 2'b00, 3'b010);
        tick();
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        drive(0, 32'h8, 32'h0, 5'd2, 1, 2'b00, 3'b010);
        tick(); check("cnt_wrap", 64'(o_cnt), 64'd0);

        // Reset mid-stall discards the held instruction.
        drive(1, 32'hC, 32'hFFFF_FFFF, 5'd6, 1, 2'b01, 3'b000);
        tick();
        stall = 1;
        tick();
        rst = 1;
        tick();
        check("rst_stall_valid", 64'(o_valid), 64'd0);
        check("rst_stall_cnt", 64'(o_cnt), 64'd0);
        rst = 0; stall = 0;
        drive(0, 32'h0, 32'h0, 5'd0, 0, 2'b00, 3'b000);
        tick(); check("post_rst_cnt", 64'(o_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_wb_reg.md
MEM_WB_REG -- requirements
Module: mem_wb_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of all data buses.
REQ-002 SHALL have ports i_clk (input, 1, rising-edge clock) and i_rst (input, 1, reset); one clock; reset is synchronous and active-high.
REQ-003 SHALL have port i_stall (input, 1): hold WB contents.
REQ-004 SHALL have port i_flush (input, 1): insert bubble into WB.
REQ-005 SHALL have port i_valid (input, 1): MEM-stage instruction valid.
REQ-006 SHALL have port i_alu_result (input, DATA_WIDTH): ALU result / load address.
REQ-007 SHALL have port i_rdata (input, DATA_WIDTH): raw aligned memory word.
REQ-008 SHALL have port i_pc_plus4 (input, DATA_WIDTH): PC+4 of the MEM instruction.
REQ-009 SHALL have port i_rd_addr (input, 5): destination register.
REQ-010 SHALL have port i_reg_write (input, 1): destination write enable.
REQ-011 SHALL have port i_result_src (input, 2): writeback source select.
REQ-012 SHALL have port i_funct3 (input, 3): load size/sign code.
REQ-013 SHALL have ports o_valid (output, 1), o_alu_result, o_load_data, o_pc_plus4 (outputs, DATA_WIDTH), o_rd_addr (output, 5), o_reg_write (output, 1), o_result_src (output, 2), o_retire_cnt (output, 32); o_alu_result, o_load_data and o_pc_plus4 feed the 3-to-1 writeback mux data inputs 0/1/2, and o_result_src drives its select.

Function
REQ-014 SHALL capture all inputs on the rising i_clk edge when i_stall=0 and i_flush=0; latency exactly 1 cycle.
REQ-015 SHALL hold every output register unchanged while i_stall=1 and i_flush=0.
REQ-016 SHALL, on i_flush=1, load a bubble regardless of i_stall: o_valid=0, o_reg_write=0, o_rd_addr=0, o_result_src=00, data outputs 0.
REQ-017 SHALL register o_reg_write = i_reg_write AND i_valid AND (i_rd_addr != 0); x0 writes are always suppressed.
REQ-018 SHALL compute o_load_data at capture from i_rdata with byte offset i_alu_result[1:0].
REQ-019 SHALL implement funct3 000 LB (sign-extend selected byte) and 100 LBU (zero-extend selected byte).
REQ-020 SHALL implement funct3 001 LH and 101 LHU, selecting the halfword with i_alu_result[1]; i_alu_result[0] is ignored.
REQ-021 SHALL implement funct3 010 LW as i_rdata unmodified, ignoring i_alu_result[1:0].
REQ-022 SHALL pass i_rdata unmodified for funct3 011, 110 and 111.
REQ-023 SHALL increment o_retire_cnt by 1 on each edge where o_valid=1 and (i_stall=0 or i_flush=1); one instruction counts once however long it is stalled.
REQ-024 SHALL wrap o_retire_cnt from 32'hFFFF_FFFF to 0 without flag.
REQ-025 SHALL treat i_result_src=11 identically to 10 (PC+4 source) and store it unchanged.

Reset
REQ-026 SHALL, when i_rst=1 at a rising edge, clear all outputs to 0, including o_retire_cnt, overriding i_flush and i_stall.
REQ-027 SHALL produce the bubble state as the first post-reset state; reset mid-stall discards the held instruction and does not count it.

Structure
REQ-028 SHALL place result-source constants (RESULT_ALU=00, RESULT_MEM=01, RESULT_PC4=10) and load funct3 constants in the shared processor package.
REQ-029 SHALL implement extraction and extension in a combinational sub-module load_extend; the pipeline registers and counter live in mem_wb_reg.

Verification
REQ-030 SHALL check LB: i_rdata=32'h80FF_7F01, alu[1:0]=11, funct3=000 -> o_load_data=32'hFFFF_FF80 next cycle; LBU same -> 32'h0000_0080.
REQ-031 SHALL check LH/LW: i_rdata=32'h8001_1234, alu[1]=1, funct3=001 -> 32'hFFFF_8001; funct3=010, alu=...3 -> 32'h8001_1234.
REQ-032 SHALL check stall/flush: capture rd=5 write; i_stall=1 for 3 cycles -> outputs held, o_retire_cnt +1 only after release; i_stall=1 with i_flush=1 -> bubble next cycle.
REQ-033 SHALL check x0 suppression: i_valid=1, i_reg_write=1, i_rd_addr=0 -> o_reg_write=0, o_valid=1.
REQ-034 SHALL check counter wrap: force o_retire_cnt=32'hFFFF_FFFF with valid instruction retiring -> 0 next edge; i_rst=1 mid-stall -> all outputs 0 next edge.
